// File: rtl/oam_data_port.sv
// OAMADDR/OAMDATA responder: owns the OAM address counter, a one-entry write buffer and the OAM strobes.
// Optional build macro OAM_ATTR_MASK_EN: attribute bytes (addr[1:0]=2'b10) mask bits 4:2 on read and write.
//   state | meaning
//   IDLE  | no buffered write; OAM_Addr follows OAMADDR
//   WPEND | byte buffered, waiting for a free OAM port cycle
module oam_data_port #(
  parameter logic [7:0] OAMADDR_INIT = 8'h00,
  parameter int         RENDER_STEP  = 4
) (
  input  logic       PCLK,
  input  logic       RES,
  input  logic       n_DBE,
  input  logic [2:0] RS,
  input  logic       RnW,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  input  logic       Render,
  input  logic       OAM_Busy,
  input  logic [7:0] OAM_RData,
  output logic [7:0] OAM_Addr,
  output logic [7:0] OAM_WData,
  output logic       OAM_WE,
  output logic       Overrun
);

  typedef enum logic {IDLE, WPEND} state_t;

  state_t     state, state_nxt;
  logic       n_dbe_q;
  logic [7:0] oamaddr;
  logic [7:0] buffer;
  logic [7:0] addr_buf;
  logic [7:0] pend_addr;
  logic       pend_valid;
  logic       rd_cap;
  logic [7:0] rdata_m;

  logic acc, wr_addr, wr_data, rd_data;

  assign acc     = n_dbe_q & ~n_DBE;
  assign wr_addr = acc & (RS == 3'd3) & ~RnW;
  assign wr_data = acc & (RS == 3'd4) & ~RnW;
  assign rd_data = acc & (RS == 3'd4) & RnW;

  assign OAM_Addr = (state == WPEND) ? addr_buf : oamaddr;
  // Drive only after capture so a new access never inherits the previous read's enable.
  assign DB_oe    = ~RES & ~n_DBE & ~acc & rd_cap;

`ifdef OAM_ATTR_MASK_EN
  assign rdata_m   = (OAM_Addr[1:0] == 2'b10) ? (OAM_RData & 8'hE3) : OAM_RData;
  assign OAM_WData = (addr_buf[1:0] == 2'b10) ? (buffer & 8'hE3) : buffer;
`else
  assign rdata_m   = OAM_RData;
  assign OAM_WData = buffer;
`endif

  always_ff @(posedge PCLK) begin
    if (RES) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    OAM_WE    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_data && !Render) state_nxt = WPEND;
      end
      WPEND: begin
        // Render also holds the write off: sprite evaluation owns the port.
        if (!RES && !OAM_Busy && !Render) begin
          OAM_WE    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RES) begin
      n_dbe_q    <= 1'b1;
      oamaddr    <= OAMADDR_INIT;
      buffer     <= 8'h00;
      addr_buf   <= 8'h00;
      pend_addr  <= 8'h00;
      pend_valid <= 1'b0;
      rd_cap     <= 1'b0;
      DB_out     <= 8'h00;
      Overrun    <= 1'b0;
    end else begin
      n_dbe_q <= n_DBE;
      if (acc)     rd_cap <= (RS == 3'd4) & RnW;
      if (rd_data) DB_out <= rdata_m;
      case (state)
        IDLE: begin
          if (wr_addr) begin
            oamaddr <= DB_in;
          end else if (wr_data) begin
            if (Render) begin
              oamaddr <= oamaddr + 8'(RENDER_STEP);
            end else begin
              buffer   <= DB_in;
              addr_buf <= oamaddr;
            end
          end
        end
        WPEND: begin
          if (wr_data) Overrun <= 1'b1;
          if (OAM_WE) begin
            // A $2003 write landing on the exit edge is the latest value and wins.
            pend_valid <= 1'b0;
            if (wr_addr)         oamaddr <= DB_in;
            else if (pend_valid) oamaddr <= pend_addr;
            else                 oamaddr <= addr_buf + 8'd1;
          end else if (wr_addr) begin
            pend_addr  <= DB_in;
            pend_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
